inst_fetch: RTL
===============

# inst_fetch

Instruction-fetch stage of the MIPS pipeline CPU: the reader side of the instruction memory. It owns the PC, drives the word address into the combinational-read instruction memory, and captures the returned word into the IF/ID pipeline register. It obeys stall, flush and redirect requests from the hazard and branch logic, and stops fetching when it sees the halt sentinel word.

## Interface

Parameters:
- `AW`, 8, instruction-memory word-address width.
- `RESET_PC`, 32'h0000_0004, PC after reset. Word 0 holds the sentinel, so fetch starts at word 1.
- `HALT_WORD`, 32'hFFFF_FFFF, fetched word that halts fetch.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `inst_addr`  out  AW  word address to instruction memory, `pc[AW+1:2]`, combinational from the PC register.
- `inst_data`  in  32  instruction word returned combinationally by the memory in the same cycle.
- `stall`  in  1  hold the PC and IF/ID contents.
- `flush`  in  1  squash IF/ID (insert a bubble).
- `redirect_valid`  in  1  branch or jump taken.
- `redirect_pc`  in  32  target byte address.
- `pc`  out  32  current fetch PC.
- `if_id_pc`  out  32  PC of the captured instruction.
- `if_id_pc4`  out  32  `if_id_pc + 4`.
- `if_id_inst`  out  32  captured instruction; 32'h0 (nop) when invalid.
- `if_id_valid`  out  1  IF/ID holds a real instruction.
- `halted`  out  1  fetch stopped on `HALT_WORD`.

## Operation

Reset values:
- `pc` = RESET_PC.
- `if_id_pc`, `if_id_pc4`, `if_id_inst` = 0.
- `if_id_valid` = 0, `halted` = 0.
- FSM in RUN.

FSM, two states:
- **RUN** → **HALT** when `inst_data == HALT_WORD` in a cycle with no rst, no redirect_valid and no stall.
- **HALT** is left only by rst.

Per-cycle update in RUN. The first matching row wins; priority is rst > redirect > halt detect > stall/flush.
- **redirect_valid=1**: `pc <= {redirect_pc[31:2],2'b00}` (misaligned low bits forced to 0). IF/ID gets a bubble. This overrides stall and flush.
- **Halt detect**: pc holds. IF/ID gets a bubble, so the sentinel is never issued. `halted <= 1`.
- **stall=1, flush=0**: pc and IF/ID hold.
- **stall=1, flush=1**: pc holds; IF/ID gets a bubble.
- **stall=0, flush=1**: `pc <= pc+4`; IF/ID gets a bubble.
- **Otherwise**: `pc <= pc+4`; IF/ID loads `{pc, pc+4, inst_data, valid=1}`.

"Bubble" means `if_id_valid=0` and `if_id_inst=0`. `if_id_pc` and `if_id_pc4` are don't-care and are cleared to 0.

HALT state:
- pc frozen.
- IF/ID holds the bubble.
- stall, flush and redirect_valid are ignored.
- `halted` stays 1.

Arithmetic and boundaries:
- `pc+4` is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.
- `inst_addr` takes only `pc[AW+1:2]`, so fetch wraps modulo 2^AW words (word 255 → word 0 at AW=8).
- Redirect to the current PC is legal and refetches that word.
- rst asserted in any state restores all reset values on the next edge, regardless of other inputs.

## Timing

- `inst_addr` is valid the same cycle the PC register updates; there are no extra cycles of address latency.
- Latency: a word at PC p, fetched in cycle n, appears on `if_id_inst` after the edge ending cycle n.
- Sustained throughput is 1 instruction/cycle when not stalled.
- A redirect asserted in cycle n:
  - target is fetched in cycle n+1;
  - target appears on IF/ID after the edge ending n+1;
  - exactly one bubble reaches IF/ID.
- Halt:
  - `halted` rises after the edge ending the cycle in which the sentinel was presented;
  - the instruction preceding the sentinel is still delivered normally.
- All outputs are registered except `inst_addr` (a pure slice of the `pc` register).

## Structure

- Shared package `mips_pkg`:
  - `HALT_WORD`;
  - `RESET_PC`;
  - `NOP_INST` = 32'h0;
  - fetch FSM enum `fetch_state_t {RUN, HALT}`.
- One sub-module, `if_id_reg`:
  - holds pc, pc4, inst, valid;
  - inputs: load, bubble, hold, rst;
  - reused later by the other pipeline registers.
- The PC register, next-PC mux and FSM stay in `inst_fetch`.

## Test plan

- **Reset and straight-line fetch.** Release rst with a memory model (word0=FFFFFFFF, word1=20010009, word2=00001020) → `inst_addr`=1 then 2. IF/ID shows `{pc=4, inst=20010009, valid=1}`, then `{pc=8, inst=00001020}`. `if_id_pc4`=8, then 12.
- **Stall.** Stall for 2 cycles at pc=0x10 → pc and IF/ID unchanged for 2 cycles. Fetch resumes at 0x10 with no skipped or duplicated word.
- **Redirect combined with stall and flush.** Assert redirect_valid=1, redirect_pc=0x23, stall=1, flush=1 in the same cycle → next pc=0x20, one bubble in IF/ID (valid=0, inst=0). The word at 0x20 is valid on the following cycle.
- **Flush without stall.** Assert flush at pc=0x0C → IF/ID becomes a bubble and pc advances to 0x10.
- **Halt.** Place FFFFFFFF at word 5 → after word 4 is delivered, `halted`=1, pc stays 0x14 and `if_id_valid`=0. A later redirect is ignored; rst restores pc=4 and `halted`=0.
- **Wrap.** Set pc to 0x3FC via redirect (AW=8) → `inst_addr`=255, then pc=0x400 and `inst_addr`=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: constants and types shared by the MIPS pipeline stages.
//   HALT_WORD     - instruction word that stops instruction fetch
//   RESET_PC      - fetch address after reset (word 0 holds the sentinel)
//   NOP_INST      - encoding placed in pipeline registers for a bubble
//   fetch_state_t - fetch-stage state: RUN (fetching) or HALT (stopped)
package mips_pkg;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] RESET_PC  = 32'h0000_0004;
    localparam logic [31:0] NOP_INST  = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: one pipeline register slot carrying {pc, pc4, inst, valid}.
// Written generically so the later pipeline registers can reuse it.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   synchronous, active-high; clears the slot
//   load     in   capture new_pc/new_pc4/new_inst and mark valid
//   bubble   in   clear the slot (valid=0, inst=nop, pcs=0)
//   hold     in   keep current contents (blocks load)
//   new_pc   in   pc of the instruction being captured
//   new_pc4  in   pc+4 of the instruction being captured
//   new_inst in   instruction word being captured
//   pc, pc4, inst, valid  out  registered slot contents
// Priority: rst > bubble > hold > load; otherwise the slot holds.
module if_id_reg
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        bubble,
    input  logic        hold,
    input  logic [31:0] new_pc,
    input  logic [31:0] new_pc4,
    input  logic [31:0] new_inst,
    output logic [31:0] pc,
    output logic [31:0] pc4,
    output logic [31:0] inst,
    output logic        valid
);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            pc    <= 32'h0;
            pc4   <= 32'h0;
            inst  <= NOP_INST;
            valid <= 1'b0;
        end else if (load && !hold) begin
            pc    <= new_pc;
            pc4   <= new_pc4;
            inst  <= new_inst;
            valid <= 1'b1;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage. Owns the PC, presents the word
// address to a combinational-read instruction memory and captures the
// returned word into the IF/ID register. Obeys stall/flush/redirect and
// stops for good (until rst) when the halt sentinel word is fetched.
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   inst_addr  out   word address pc[AW+1:2] (pure slice of pc register)
//   inst_data  in    instruction word for inst_addr, same cycle
//   stall      in    hold pc and IF/ID
//   flush      in    squash IF/ID
//   redirect_valid/redirect_pc  in  taken branch/jump target (byte addr)
//   pc         out   current fetch PC
//   if_id_pc/if_id_pc4/if_id_inst/if_id_valid  out  IF/ID contents
//   halted     out   fetch stopped on HALT_WORD
module inst_fetch #(
    parameter int          AW        = 8,
    parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
    parameter logic [31:0] HALT_WORD = mips_pkg::HALT_WORD
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] inst_addr,
    input  logic [31:0]   inst_data,
    input  logic          stall,
    input  logic          flush,
    input  logic          redirect_valid,
    input  logic [31:0]   redirect_pc,
    output logic [31:0]   pc,
    output logic [31:0]   if_id_pc,
    output logic [31:0]   if_id_pc4,
    output logic [31:0]   if_id_inst,
    output logic          if_id_valid,
    output logic          halted
);

    mips_pkg::fetch_state_t state, state_next;

    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        load;
    logic        bubble;
    logic        hold;

    assign pc_plus4  = pc + 32'd4;   // 32-bit modulo by construction
    assign inst_addr = pc[AW+1:2];
    assign halted    = (state == mips_pkg::HALT);

    // Next-PC mux and FSM. Row order encodes priority:
    // redirect > halt detect > stall/flush > normal fetch.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned and infers a latch.
        pc_next    = pc;
        state_next = state;
        load       = 1'b0;
        bubble     = 1'b0;
        hold       = 1'b0;
        case (state)
            mips_pkg::RUN: begin
                if (redirect_valid) begin
                    pc_next = {redirect_pc[31:2], 2'b00};
                    bubble  = 1'b1;
                end else if (inst_data == HALT_WORD && !stall) begin
                    // Sentinel is never issued; pc stays on it.
                    bubble     = 1'b1;
                    state_next = mips_pkg::HALT;
                end else if (stall) begin
                    hold   = 1'b1;
                    bubble = flush;
                end else begin
                    pc_next = pc_plus4;
                    bubble  = flush;
                    load    = !flush;
                end
            end
            default: begin
                // HALT: everything frozen, IF/ID kept as a bubble.
                bubble = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= RESET_PC;
            state <= mips_pkg::RUN;
        end else begin
            pc    <= pc_next;
            state <= state_next;
        end
    end

    if_id_reg u_if_id (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .bubble   (bubble),
        .hold     (hold),
        .new_pc   (pc),
        .new_pc4  (pc_plus4),
        .new_inst (inst_data),
        .pc       (if_id_pc),
        .pc4      (if_id_pc4),
        .inst     (if_id_inst),
        .valid    (if_id_valid)
    );

endmodule
